// File: rtl/iter_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// Restoring division, one quotient bit per cycle, pipeline stalled meanwhile.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_nx;

    logic             is_rem, neg_q, neg_r;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic [CW-1:0]    cnt;

    logic             sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             div0, ovf, special, accept, last;
    logic [WIDTH-1:0] spec_res;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_step, r_step, fin_res;

    assign sgn_op  = ~op[0];
    assign a_neg   = sgn_op & a[WIDTH-1];
    assign b_neg   = sgn_op & b[WIDTH-1];
    assign a_abs   = a_neg ? -a : a;
    assign b_abs   = b_neg ? -b : b;
    assign div0    = (b == '0);
    assign ovf     = sgn_op & (a == MIN) & (b == '1);
    assign special = div0 | ovf;
    assign accept  = (state == IDLE) & start & ~flush;
    assign last    = (state == CALC) & (cnt == CW'(1));

    assign spec_res = div0 ? (op[1] ? a : '1)
                           : (op[1] ? '0 : MIN);

    // Shift {rem,quo} left one and try subtracting the divisor.
    assign trial  = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    assign q_step = {quo[WIDTH-2:0], ~trial[WIDTH]};
    assign r_step = trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]}
                                 : trial[WIDTH-1:0];

    assign fin_res = is_rem ? (neg_r ? -r_step : r_step)
                            : (neg_q ? -q_step : q_step);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stall    = 1'b1;
                    state_nx = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    stall = 1'b1;
                    if (last) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            cnt    <= '0;
        end else begin
            done <= (state_nx == DONE);
            if (accept) begin
                is_rem <= op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                quo    <= a_abs;
                rem    <= '0;
                dvs    <= b_abs;
                cnt    <= CW'(WIDTH);
                if (special) result <= spec_res;
            end else if ((state == CALC) && !flush) begin
                quo <= q_step;
                rem <= r_step;
                cnt <= cnt - CW'(1);
                if (last) result <= fin_res;
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: vector table, random ops against a
// behavioural model, and hand sequences for flush, held start and reset.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    iter_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .op(op), .a(a), .b(b),
        .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            DIV:     return $signed(x) / $signed(y);
            DIVU:    return x / y;
            REM:     return $signed(x) % $signed(y);
            default: return x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return 2;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Cycle 1 is the start cycle; done must appear in cycle lat.
    task automatic do_op(input string name, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int lat);
        int n, st;
        bit got;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(exp);
        last_exp = exp;
        n = 1; st = 0; got = 1'b0;
        while (n <= 100 && !got) begin
            #1;
            if (stall) st++;
            if (done) begin
                got = 1'b1;
                chk32({name, "_result"}, result, exp_q.pop_front());
                chk_int({name, "_latency"}, n, lat);
            end else begin
                @(negedge clk);
                n++;
                start = 1'b0;
                a = $urandom;
                b = $urandom;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done required done in cycle %0d", name, lat);
            void'(exp_q.pop_front());
        end
        chk_int({name, "_stall_cycles"}, st, lat - 1);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         34};
        vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          34};
        vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vecs[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vecs[4]  = '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        vecs[5]  = '{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  2};
        vecs[6]  = '{REMU, 32'h1234,       32'd0,          32'h1234,       2};
        vecs[7]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
        vecs[8]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          2};
        vecs[9]  = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        vecs[10] = '{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34};
        vecs[11] = '{REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34};
        vecs[12] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          34};
        vecs[13] = '{REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
        vecs[14] = '{DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  34};
        vecs[15] = '{DIVU, 32'd3,          32'd5,          32'd0,          34};

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        op = 2'b00; a = '0; b = '0; last_exp = '0;
        @(negedge clk);
        #1;
        chk_int("reset_done", int'(done), 0);
        chk32("reset_result", result, 32'h0);
        chk_int("reset_stall", int'(stall), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                  vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom >> $urandom_range(0, 28);
            do_op($sformatf("rnd%0d", i), o, x, y, ref_div(o, x, y), ref_lat(o, x, y));
        end

        // Flush in the tenth CALC cycle.
        begin
            int seen;
            @(negedge clk);
            start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
            @(negedge clk);
            start = 1'b0;
            repeat (9) @(negedge clk);
            flush = 1'b1;
            #1;
            chk_int("flush_stall_drop", int'(stall), 0);
            @(negedge clk);
            flush = 1'b0;
            seen = 0;
            repeat (40) begin
                #1;
                if (done) seen++;
                @(negedge clk);
            end
            chk_int("flush_no_done", seen, 0);
            chk32("flush_result_kept", result, last_exp);
            chk_int("flush_idle_stall", int'(stall), 0);
        end
        do_op("after_flush", DIVU, 32'd100, 32'd10, 32'd10, 34);

        // Flush beats start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = DIV; a = 32'd5; b = 32'd0;
        #1;
        chk_int("idle_flush_stall", int'(stall), 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk_int("idle_flush_no_done", int'(done), 0);

        // Start held through the whole operation.
        begin
            int dones;
            bit hold;
            @(negedge clk);
            start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
            last_exp = 32'd14;
            dones = 0; hold = 1'b1;
            repeat (45) begin
                @(negedge clk);
                #1;
                if (done) begin
                    dones++;
                    if (hold) chk32("held_result", result, 32'd14);
                    hold = 1'b0;
                    start = 1'b0;
                end
            end
            start = 1'b0;
            chk_int("held_done_count", dones, 1);
        end

        // Async reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd12345; b = 32'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_int("midreset_done", int'(done), 0);
        chk32("midreset_result", result, 32'h0);
        chk_int("midreset_stall", int'(stall), 0);
        @(negedge clk);
        reset = 1'b0;
        do_op("after_reset", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
